// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared FSM encoding and debounce defaults for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_ADJ   = 2'd2
    } sw_state_e;

    localparam int DB_SAMPLES_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, sampled debounce counter and press pulse
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_SAMPLES = DB_SAMPLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_sample,
    input  logic btn_raw,
    output logic press
);

    localparam logic [3:0] DB_MAX = 4'(DB_SAMPLES);

    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       level_q;
    logic       level_d;
    logic       press_q;
    logic       press_d;

    // Saturating count of consecutive high samples; level follows the count, pulse marks its rise
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick_sample) begin
            if (sync2_q) begin
                if (cnt_q != DB_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
                level_d = (cnt_d == DB_MAX);
            end else begin
                cnt_d   = 4'd0;
                level_d = 1'b0;
            end
        end
        press_d = level_d & ~level_q;
    end

    // Two-flop synchronizer plus debounce state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= 4'd0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM; SW_CTRL_BLINK_EN enables blinking of the adjusted field
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_SAMPLES = DB_SAMPLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_sample,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_sel,
    input  logic       sw_adj,
    output logic       cnt_clr,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       blink_on,
    output logic [1:0] state
);

    logic      pause_press;
    logic      reset_press;
    sw_state_e state_q;
    sw_state_e state_d;
    logic      cnt_clr_q;
    logic      cnt_clr_d;
    logic      inc_sec_q;
    logic      inc_sec_d;
    logic      inc_min_q;
    logic      inc_min_d;

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_pause (
        .clk         (clk),
        .rst         (rst),
        .tick_sample (tick_sample),
        .btn_raw     (btn_pause),
        .press       (pause_press)
    );

    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_reset (
        .clk         (clk),
        .rst         (rst),
        .tick_sample (tick_sample),
        .btn_raw     (btn_reset),
        .press       (reset_press)
    );

    // Next state and counter commands, all judged against the current (pre-transition) state
    always_comb begin
        state_d   = state_q;
        cnt_clr_d = 1'b0;
        inc_sec_d = 1'b0;
        inc_min_d = 1'b0;
        if (reset_press) begin
            cnt_clr_d = 1'b1;
            state_d   = ST_PAUSE;
        end else begin
            case (state_q)
                ST_PAUSE: begin
                    if (sw_adj) begin
                        state_d = ST_ADJ;
                    end else if (pause_press) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    inc_sec_d = tick_1hz;
                    if (sw_adj) begin
                        state_d = ST_ADJ;
                    end else if (pause_press) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_ADJ: begin
                    if (tick_2hz) begin
                        inc_sec_d = sw_sel;
                        inc_min_d = ~sw_sel;
                    end
                    if (!sw_adj) begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_PAUSE;
                end
            endcase
        end
    end

    // Registered state and single-cycle command outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PAUSE;
            cnt_clr_q <= 1'b0;
            inc_sec_q <= 1'b0;
            inc_min_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_clr_q <= cnt_clr_d;
            inc_sec_q <= inc_sec_d;
            inc_min_q <= inc_min_d;
        end
    end

`ifdef SW_CTRL_BLINK_EN
    logic blink_q;
    logic blink_d;

    // Blink toggles on each adjust tick while adjusting and reads solid outside adjust
    always_comb begin
        blink_d = blink_q;
        if (state_d != ST_ADJ) begin
            blink_d = 1'b1;
        end else if (state_q == ST_ADJ && tick_2hz) begin
            blink_d = ~blink_q;
        end
    end

    // Blink register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= 1'b1;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink_on = blink_q;
`else
    assign blink_on = 1'b1;
`endif

    assign cnt_clr = cnt_clr_q;
    assign inc_sec = inc_sec_q;
    assign inc_min = inc_min_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - randomized and directed checks of stopwatch_ctrl against an operation-level model
module tb_stopwatch_ctrl;

    localparam int DB = 4;
    localparam int ST_P = 0;
    localparam int ST_R = 1;
    localparam int ST_A = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       tick_sample = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_reset = 1'b0;
    logic       sw_sel = 1'b0;
    logic       sw_adj = 1'b0;
    logic       cnt_clr;
    logic       inc_sec;
    logic       inc_min;
    logic       blink_on;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    int m_state = ST_P;
    int m_blink = 1;
    int m_run_p = 0;
    int m_run_r = 0;

    int n_clr, n_sec, n_min, n_excl;

    stopwatch_ctrl #(.DB_SAMPLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .tick_sample (tick_sample),
        .btn_pause   (btn_pause),
        .btn_reset   (btn_reset),
        .sw_sel      (sw_sel),
        .sw_adj      (sw_adj),
        .cnt_clr     (cnt_clr),
        .inc_sec     (inc_sec),
        .inc_min     (inc_min),
        .blink_on    (blink_on),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_clr = 0; n_sec = 0; n_min = 0; n_excl = 0;
    endtask

    // one clock, observing outputs 1 time unit after the edge
    task automatic cycle();
        @(posedge clk);
        #1;
        n_clr += int'(cnt_clr);
        n_sec += int'(inc_sec);
        n_min += int'(inc_min);
        if ((inc_sec && inc_min) || (cnt_clr && (inc_sec || inc_min))) n_excl++;
    endtask

    task automatic check_op(input string tag, input int e_clr, input int e_sec, input int e_min);
        check({tag, "_clr"}, n_clr, e_clr);
        check({tag, "_sec"}, n_sec, e_sec);
        check({tag, "_min"}, n_min, e_min);
        check({tag, "_excl"}, n_excl, 0);
        check({tag, "_state"}, int'(state), m_state);
        check({tag, "_blink"}, int'(blink_on), m_blink);
    endtask

    // hold button levels, then take one debounce sample
    task automatic btn_op(input bit p, input bit r);
        bit pp, pr;
        btn_pause = p;
        btn_reset = r;
        clear_counts();
        repeat (3) cycle();
        tick_sample = 1'b1;
        cycle();
        tick_sample = 1'b0;
        repeat (2) cycle();
        pp = p && (m_run_p == DB - 1);
        pr = r && (m_run_r == DB - 1);
        m_run_p = p ? ((m_run_p < DB) ? m_run_p + 1 : DB) : 0;
        m_run_r = r ? ((m_run_r < DB) ? m_run_r + 1 : DB) : 0;
        if (pr) begin
            m_state = sw_adj ? ST_A : ST_P;
            m_blink = 1;
        end else if (pp && m_state != ST_A) begin
            m_state = (m_state == ST_R) ? ST_P : ST_R;
        end
        check_op("btn", pr ? 1 : 0, 0, 0);
    endtask

    task automatic tick1_op();
        int e;
        e = (m_state == ST_R) ? 1 : 0;
        clear_counts();
        tick_1hz = 1'b1;
        cycle();
        tick_1hz = 1'b0;
        check("sec_latency", int'(inc_sec), e);
        repeat (2) cycle();
        check_op("t1", 0, e, 0);
    endtask

    task automatic tick2_op();
        int es, em;
        es = (m_state == ST_A && sw_sel) ? 1 : 0;
        em = (m_state == ST_A && !sw_sel) ? 1 : 0;
`ifdef SW_CTRL_BLINK_EN
        if (m_state == ST_A) m_blink = 1 - m_blink;
`endif
        clear_counts();
        tick_2hz = 1'b1;
        cycle();
        tick_2hz = 1'b0;
        check("adj_latency", int'(inc_sec) + 2 * int'(inc_min), es + 2 * em);
        repeat (2) cycle();
        check_op("t2", 0, es, em);
    endtask

    task automatic sw_op(input bit adj, input bit sel);
        sw_adj = adj;
        sw_sel = sel;
        if (adj && m_state != ST_A) m_state = ST_A;
        if (!adj && m_state == ST_A) begin
            m_state = ST_P;
            m_blink = 1;
        end
        clear_counts();
        repeat (2) cycle();
        check_op("sw", 0, 0, 0);
    endtask

    // assert rst between edges, outputs must clear without a clock
    task automatic async_reset();
        tick_1hz = 1'b1;
        @(posedge clk);
        #3;
        check("pre_rst_sec", int'(inc_sec), (m_state == ST_R) ? 1 : 0);
        rst = 1'b1;
        #1;
        check("rst_state", int'(state), ST_P);
        check("rst_clr", int'(cnt_clr), 0);
        check("rst_sec", int'(inc_sec), 0);
        check("rst_min", int'(inc_min), 0);
        check("rst_blink", int'(blink_on), 1);
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = sw_adj ? ST_A : ST_P;
        m_blink = 1;
        m_run_p = 0;
        m_run_r = 0;
        repeat (2) cycle();
    endtask

    task automatic press_pause();
        btn_op(1'b0, 1'b0);
        repeat (DB) btn_op(1'b1, 1'b0);
        btn_op(1'b0, 1'b0);
    endtask

    initial begin
        #1;
        check("init_state", int'(state), ST_P);
        check("init_clr", int'(cnt_clr), 0);
        check("init_sec", int'(inc_sec), 0);
        check("init_min", int'(inc_min), 0);
        check("init_blink", int'(blink_on), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // held press: one toggle only
        repeat (DB + 20) btn_op(1'b1, 1'b0);
        check("hold_state", int'(state), ST_R);
        btn_op(1'b0, 1'b0);

        // bounce H L H H H then a fourth consecutive high
        btn_op(1'b1, 1'b0);
        btn_op(1'b0, 1'b0);
        repeat (3) btn_op(1'b1, 1'b0);
        check("bounce_hold", int'(state), ST_R);
        btn_op(1'b1, 1'b0);
        check("bounce_press", int'(state), ST_P);
        btn_op(1'b0, 1'b0);

        // run ticks
        press_pause();
        repeat (5) tick1_op();

        // adjust minutes
        sw_op(1'b1, 1'b0);
        repeat (3) tick2_op();
        sw_op(1'b1, 1'b1);
        tick2_op();
        sw_op(1'b0, 1'b1);

        // reset and pause presses together in RUN
        press_pause();
        btn_op(1'b0, 1'b0);
        repeat (DB) btn_op(1'b1, 1'b1);
        check("coincide_state", int'(state), ST_P);
        btn_op(1'b0, 1'b0);

        // reset mid-debounce and mid-RUN, button held through reset
        press_pause();
        repeat (DB - 1) btn_op(1'b1, 1'b0);
        async_reset();
        repeat (DB) btn_op(1'b1, 1'b0);
        btn_op(1'b0, 1'b0);

        // randomized operations
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: btn_op($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
                3, 4:    tick1_op();
                5, 6:    tick2_op();
                7, 8:    sw_op($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
                default: async_reset();
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DB_SAMPLES, default 4, giving the consecutive high samples that accept a button press (range 2..15).
REQ-002 The block SHALL have port clk, input, 1, master clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port tick_1hz, input, 1, single-cycle run strobe.
REQ-005 The block SHALL have port tick_2hz, input, 1, single-cycle adjust strobe.
REQ-006 The block SHALL have port tick_sample, input, 1, single-cycle debounce sample strobe.
REQ-007 The block SHALL have ports btn_pause and btn_reset, input, 1 each, raw asynchronous buttons.
REQ-008 The block SHALL have ports sw_sel (1 = seconds, 0 = minutes) and sw_adj (1 = adjust), input, 1 each.
REQ-009 The block SHALL have ports cnt_clr, inc_sec and inc_min, output, 1 each, single-cycle counter commands.
REQ-010 The block SHALL have ports blink_on (output, 1, display-enable for the adjusted field) and state (output, 2, current FSM state).

Function
REQ-011 The block SHALL pass each button through a 2-flop synchronizer, then a saturating sample counter advanced only on tick_sample.
- Counter increments when the sample is high.
- Counter clears when the sample is low.
- The debounced level goes high when the counter reaches DB_SAMPLES and goes low on the first low sample.
REQ-012 The block SHALL produce a one-cycle press pulse on each rising edge of a debounced level, so holding a button produces exactly one pulse.
REQ-013 The FSM SHALL have states PAUSE=0, RUN=1 and ADJ=2; encoding 3 is illegal and SHALL recover to PAUSE on the next cycle.
REQ-014 Transition priority SHALL be: reset pulse > sw_adj > pause pulse.
- A reset pulse in any state: cnt_clr=1 for one cycle, next state PAUSE.
- sw_adj=1 in PAUSE or RUN: next state ADJ.
- sw_adj=0 in ADJ: next state PAUSE.
- A pause pulse toggles between PAUSE and RUN and is ignored in ADJ.
REQ-015 In RUN, inc_sec SHALL equal tick_1hz registered, i.e. one cycle of latency.
REQ-016 In ADJ, tick_2hz SHALL produce a one-cycle pulse one cycle later: inc_sec when sw_sel=1, inc_min when sw_sel=0.
REQ-017 A sw_sel change in ADJ SHALL take effect on the next tick_2hz; no pulse is produced for the change itself.
REQ-018 inc_sec and inc_min SHALL never be asserted together, and SHALL both be 0 in any cycle where cnt_clr=1.
REQ-019 A tick coincident with a state change SHALL be evaluated against the pre-transition state.

Reset
REQ-020 When rst is asserted, the block SHALL asynchronously clear all state as follows:
- state=PAUSE.
- cnt_clr, inc_sec and inc_min = 0.
- blink_on=1.
- Synchronizers, debounce counters and debounced levels = 0.
REQ-021 A button held high through rst deassertion SHALL still require DB_SAMPLES samples before it produces a pulse.

Configuration
REQ-022 With SW_CTRL_BLINK_EN defined, blink_on SHALL toggle on each tick_2hz while in ADJ and SHALL be forced to 1 on exit from ADJ.
REQ-023 With SW_CTRL_BLINK_EN undefined, blink_on SHALL be constant 1 and no blink register SHALL be synthesized.

Structure
REQ-024 The FSM state encoding constants and the DB_SAMPLES default SHALL live in the shared package stopwatch_pkg.
REQ-025 The debounce path (synchronizer, counter, edge pulse) SHALL be a sub-module btn_debounce, instantiated twice.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Hold btn_pause high for 4 tick_sample strobes: exactly one pause pulse, state 0->1; a further 20 samples held high produce no further pulse.
- Bounce btn_pause high-low-high-high-high, one sample each: no pulse is produced until 4 consecutive highs.
- In RUN, apply 5 tick_1hz strobes: exactly 5 inc_sec pulses, each 1 cycle after its tick, with inc_min=0.
- Set sw_adj=1 and sw_sel=0, then apply 3 tick_2hz strobes: state=2, 3 inc_min pulses, blink_on toggling (BLINK_EN) or held at 1 (no BLINK_EN); clear sw_adj: state=0.
- Make the reset pulse and pause pulse coincide in RUN: cnt_clr=1 for one cycle, state=0, no toggle occurs.
- Assert rst mid-debounce and mid-RUN: all outputs return to their reset values immediately, without waiting for a clock edge.
